alu_seq_w: RTL and testbench

- Parametrised successor to the 8-bit combinational datapath ALU: WIDTH-bit operands, a 4-bit opcode, and registered result plus status flags (C, DC, Z).
- Adds a valid/ready input handshake, a single-cycle output strobe and a multi-cycle shift-add unsigned multiply.
- Sits between the operand-select mux and the register-file/status write-back stage of the core.

---
 rtl/alu_seq_w.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq_w.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_w.sv
// Sequential ALU with registered result and C/DC/Z status, a valid/ready request port,
// a one-cycle completion strobe and a shift-add unsigned multiply that stalls new requests.
module alu_seq_w #(
    parameter int WIDTH  = 8,
    parameter int DC_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flag_load,
    input  logic [2:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             out_valid,
    output logic             c_flag,
    output logic             dc_flag,
    output logic             z_flag
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_CLR  = 4'd0,  OP_MOV = 4'd1,  OP_SWAP = 4'd2,  OP_RLF = 4'd3,
        OP_RRF  = 4'd4,  OP_IOR = 4'd5,  OP_AND  = 4'd6,  OP_XOR = 4'd7,
        OP_COMP = 4'd8,  OP_ADD = 4'd9,  OP_SUB  = 4'd10, OP_INC = 4'd11,
        OP_DEC  = 4'd12, OP_MUL = 4'd13
    } op_e;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [WIDTH-1:0]       result_hi_q, result_hi_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   c_q, c_d, dc_q, dc_d, z_q, z_d;
    logic                   out_valid_q, out_valid_d;

    // Handshake: a request transfers on a rising edge where in_valid && in_ready.
    // in_ready is low in reset and while a multiply is busy; the requester holds
    // in_valid and its operands until the transfer happens.
    assign in_ready = (state_q == ST_IDLE) && !rst;

    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [DC_BIT:0]  sum_lo;

    // Add and subtract share one adder; subtract is a + ~b + 1, so carry means no borrow.
    assign sub_op   = (op == OP_SUB);
    assign b_eff    = sub_op ? ~op_b : op_b;
    assign sum_full = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    assign sum_lo   = {1'b0, op_a[DC_BIT-1:0]} + {1'b0, b_eff[DC_BIT-1:0]}
                    + {{DC_BIT{1'b0}}, sub_op};

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_dc, alu_wr_c, alu_wr_dc, alu_wr_z;

    always_comb begin
        alu_res   = op_a;
        alu_c     = c_q;
        alu_dc    = dc_q;
        alu_wr_c  = 1'b0;
        alu_wr_dc = 1'b0;
        alu_wr_z  = 1'b1;
        case (op)
            OP_CLR:  alu_res = '0;
            OP_MOV:  alu_res = op_a;
            OP_SWAP: alu_res = {op_a[HALF-1:0], op_a[WIDTH-1:HALF]};
            OP_RLF: begin
                alu_res  = {op_a[WIDTH-2:0], c_q};
                alu_c    = op_a[WIDTH-1];
                alu_wr_c = 1'b1;
            end
            OP_RRF: begin
                alu_res  = {c_q, op_a[WIDTH-1:1]};
                alu_c    = op_a[0];
                alu_wr_c = 1'b1;
            end
            OP_IOR:  alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_COMP: alu_res = ~op_a;
            OP_ADD, OP_SUB: begin
                alu_res   = sum_full[WIDTH-1:0];
                alu_c     = sum_full[WIDTH];
                alu_dc    = sum_lo[DC_BIT];
                alu_wr_c  = 1'b1;
                alu_wr_dc = 1'b1;
            end
            OP_INC:  alu_res = op_a + WIDTH'(1);
            OP_DEC:  alu_res = op_a - WIDTH'(1);
            default: alu_wr_z = 1'b0;
        endcase
    end

    logic [WIDTH:0] mul_sum;

    // One shift-add step: add the multiplicand into the upper half when the current
    // multiplier bit (LSB of the product register) is set, then shift right.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        count_d     = count_q;
        c_d         = c_q;
        dc_d        = dc_q;
        z_d         = z_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flag_load) {c_d, dc_d, z_d} = flags_in;
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mcand_d = op_a;
                        prod_d  = {{WIDTH{1'b0}}, op_b};
                        count_d = '0;
                        state_d = ST_BUSY;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        if (alu_wr_c)  c_d  = alu_c;
                        if (alu_wr_dc) dc_d = alu_dc;
                        if (alu_wr_z)  z_d  = (alu_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d     = ST_IDLE;
                    result_d    = prod_d[WIDTH-1:0];
                    result_hi_d = prod_d[2*WIDTH-1:WIDTH];
                    c_d         = |prod_d[2*WIDTH-1:WIDTH];
                    z_d         = (prod_d == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            count_q     <= '0;
            c_q         <= 1'b0;
            dc_q        <= 1'b0;
            z_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            count_q     <= count_d;
            c_q         <= c_d;
            dc_q        <= dc_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign out_valid = out_valid_q;
    assign c_flag    = c_q;
    assign dc_flag   = dc_q;
    assign z_flag    = z_q;
endmodule

// File: tb/tb_alu_seq_w.sv
// Bench for alu_seq_w: directed vectors from worked examples plus randomized traffic
// checked against an arithmetic reference model, on an 8-bit and a 16-bit instance.
module tb_alu_seq_w;
    localparam int W  = 8;
    localparam int WW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          in_valid, in_ready, flag_load, out_valid, c_flag, dc_flag, z_flag;
    logic [3:0]    op;
    logic [W-1:0]  op_a, op_b, result, result_hi;
    logic [2:0]    flags_in;

    logic          w_in_valid, w_in_ready, w_flag_load, w_out_valid, w_c_flag, w_dc_flag, w_z_flag;
    logic [3:0]    w_op;
    logic [WW-1:0] w_op_a, w_op_b, w_result, w_result_hi;
    logic [2:0]    w_flags_in;

    alu_seq_w #(.WIDTH(W), .DC_BIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .op_a(op_a), .op_b(op_b), .flag_load(flag_load), .flags_in(flags_in),
        .result(result), .result_hi(result_hi), .out_valid(out_valid),
        .c_flag(c_flag), .dc_flag(dc_flag), .z_flag(z_flag)
    );

    alu_seq_w #(.WIDTH(WW), .DC_BIT(8)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
        .op_a(w_op_a), .op_b(w_op_b), .flag_load(w_flag_load), .flags_in(w_flags_in),
        .result(w_result), .result_hi(w_result_hi), .out_valid(w_out_valid),
        .c_flag(w_c_flag), .dc_flag(w_dc_flag), .z_flag(w_z_flag)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [2:0]   expf_q[$];
    bit mc, mdc, mz;   // model status of the 8-bit instance

    typedef struct {
        int opc; int a; int b; bit fl; logic [2:0] fin;
        int er; int eh; bit ec; bit edc; bit ez;
    } vec_t;

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic void ref_alu(input int w, input int dcb, input int opc,
                                    input longint a, input longint b, input bit cs,
                                    input bit c, input bit dc, input bit z,
                                    output longint res, output longint hi,
                                    output bit nc, output bit ndc, output bit nz);
        longint m, h, d, p;
        m = (longint'(1) << w) - 1;
        h = longint'(1) << (w / 2);
        d = longint'(1) << dcb;
        res = a; hi = 0; nc = c; ndc = dc; nz = z;
        case (opc)
            0:  res = 0;
            1:  res = a;
            2:  res = (a % h) * h + a / h;
            3:  begin res = (a * 2 + longint'(cs)) & m; nc = (a >= (m + 1) / 2); end
            4:  begin res = longint'(cs) * ((m + 1) / 2) + a / 2; nc = (a % 2 == 1); end
            5:  res = a | b;
            6:  res = a & b;
            7:  res = a ^ b;
            8:  res = m - a;
            9:  begin res = (a + b) & m; nc = (a + b > m); ndc = (a % d + b % d >= d); end
            10: begin res = (a - b) & m; nc = (a >= b); ndc = (a % d >= b % d); end
            11: res = (a + 1) & m;
            12: res = (a + m) & m;
            13: begin p = a * b; res = p & m; hi = p >> w; nc = (hi != 0); nz = (p == 0); end
            default: ;
        endcase
        if (opc < 13) nz = (res == 0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive8(input int opc, input longint a, input longint b,
                          input bit fl, input logic [2:0] fin);
        in_valid = 1'b1; op = 4'(opc); op_a = W'(a); op_b = W'(b);
        flag_load = fl; flags_in = fin;
    endtask

    task automatic idle8();
        in_valid = 1'b0; flag_load = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle8();
        w_in_valid = 1'b0; w_flag_load = 1'b0; w_op = '0; w_op_a = '0; w_op_b = '0; w_flags_in = '0;
        op = '0; op_a = '0; op_b = '0; flags_in = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (result !== '0 || result_hi !== '0) begin n_err++; $display("FAIL reset_result got %h/%h exp 0/0", result_hi, result); end
        n_vec++; if ({c_flag, dc_flag, z_flag} !== 3'b000 || out_valid !== 1'b0) begin n_err++; $display("FAIL reset_flags got cdz=%b ov=%b exp 000/0", {c_flag, dc_flag, z_flag}, out_valid); end
        n_vec++; if (in_ready !== 1'b1 || w_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got %b/%b exp 1/1", in_ready, w_in_ready); end
        mc = 0; mdc = 0; mz = 0;
    endtask

    task automatic test_sub_pair();
        @(negedge clk);
        drive8(10, 'h05, 'h05, 0, 3'b000);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== 8'h00) begin n_err++; $display("FAIL sub_eq got ov=%b res=%h exp 1/00", out_valid, result); end
        n_vec++; if ({c_flag, dc_flag, z_flag} !== 3'b111) begin n_err++; $display("FAIL sub_eq_flags got %b exp 111", {c_flag, dc_flag, z_flag}); end
        drive8(10, 'h03, 'h05, 0, 3'b000);
        @(negedge clk);
        idle8();
        n_vec++; if (out_valid !== 1'b1 || result !== 8'hFE) begin n_err++; $display("FAIL sub_neg got ov=%b res=%h exp 1/fe", out_valid, result); end
        n_vec++; if ({c_flag, dc_flag, z_flag} !== 3'b000) begin n_err++; $display("FAIL sub_neg_flags got %b exp 000", {c_flag, dc_flag, z_flag}); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_strobe_end got %b exp 0", out_valid); end
        mc = 0; mdc = 0; mz = 0;
    endtask

    task automatic test_directed8();
        vec_t tbl[$];
        int lat;
        tbl.push_back('{9,  'h0F, 'h01, 0, 3'b000, 'h10, 0, 0, 1, 0});
        tbl.push_back('{-1, 0,    0,    1, 3'b011, 0,    0, 0, 1, 1});
        tbl.push_back('{3,  'h81, 0,    0, 3'b000, 'h02, 0, 1, 1, 0});
        tbl.push_back('{4,  'h02, 0,    0, 3'b000, 'h81, 0, 0, 1, 0});
        tbl.push_back('{12, 'h00, 0,    0, 3'b000, 'hFF, 0, 0, 1, 0});
        tbl.push_back('{11, 'hFF, 0,    0, 3'b000, 'h00, 0, 0, 1, 1});
        tbl.push_back('{14, 'h3C, 0,    0, 3'b000, 'h3C, 0, 0, 1, 1});
        tbl.push_back('{0,  'h77, 0,    0, 3'b000, 'h00, 0, 0, 1, 1});
        tbl.push_back('{8,  'h0F, 0,    0, 3'b000, 'hF0, 0, 0, 1, 0});
        tbl.push_back('{7,  'h5A, 'h5A, 0, 3'b000, 'h00, 0, 0, 1, 1});
        tbl.push_back('{6,  'hF0, 'h0F, 0, 3'b000, 'h00, 0, 0, 1, 1});
        tbl.push_back('{5,  'hF0, 'h0F, 0, 3'b000, 'hFF, 0, 0, 1, 0});
        tbl.push_back('{2,  'hA5, 0,    0, 3'b000, 'h5A, 0, 0, 1, 0});
        tbl.push_back('{1,  'h00, 0,    1, 3'b100, 'h00, 0, 1, 0, 1});
        tbl.push_back('{9,  'hFF, 'h01, 0, 3'b000, 'h00, 0, 1, 1, 1});
        tbl.push_back('{10, 'h10, 'h01, 0, 3'b000, 'h0F, 0, 1, 0, 0});
        tbl.push_back('{15, 'h99, 0,    1, 3'b010, 'h99, 0, 0, 1, 0});
        foreach (tbl[i]) begin
            @(negedge clk);
            if (tbl[i].opc < 0) begin
                in_valid = 1'b0; flag_load = 1'b1; flags_in = tbl[i].fin;
                @(negedge clk);
                idle8();
                n_vec++; if ({c_flag, dc_flag, z_flag} !== tbl[i].fin || out_valid !== 1'b0) begin n_err++; $display("FAIL flag_load[%0d] got cdz=%b ov=%b exp %b/0", i, {c_flag, dc_flag, z_flag}, out_valid, tbl[i].fin); end
            end else begin
                drive8(tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].fl, tbl[i].fin);
                @(negedge clk);
                idle8();
                lat = 0;
                while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
                n_vec++; if (lat != 0) begin n_err++; $display("FAIL dir_latency[%0d] got %0d exp 0", i, lat); end
                n_vec++; if (result !== W'(tbl[i].er) || result_hi !== '0) begin n_err++; $display("FAIL dir_result[%0d] op %0d got %h/%h exp 00/%h", i, tbl[i].opc, result_hi, result, W'(tbl[i].er)); end
                n_vec++; if ({c_flag, dc_flag, z_flag} !== {tbl[i].ec, tbl[i].edc, tbl[i].ez}) begin n_err++; $display("FAIL dir_flags[%0d] op %0d got %b exp %b", i, tbl[i].opc, {c_flag, dc_flag, z_flag}, {tbl[i].ec, tbl[i].edc, tbl[i].ez}); end
                @(negedge clk);
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_strobe_end[%0d] got %b exp 0", i, out_valid); end
            end
            mc = tbl[i].ec; mdc = tbl[i].edc; mz = tbl[i].ez;
        end
    endtask

    task automatic test_mul_hold();
        int lat, busy;
        @(negedge clk);
        in_valid = 1'b0; flag_load = 1'b1; flags_in = 3'b000;
        @(negedge clk);
        drive8(13, 'hFF, 'hFF, 0, 3'b000);
        @(negedge clk);
        // request held through BUSY; flag_load here must not touch the status until IDLE
        drive8(1, 'h5A, 'h00, 1, 3'b010);
        lat = 0; busy = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready === 1'b0) busy++;
            @(negedge clk); lat++;
        end
        n_vec++; if (lat != W) begin n_err++; $display("FAIL mul_latency got %0d exp %0d", lat, W); end
        n_vec++; if (busy != W) begin n_err++; $display("FAIL mul_busy_cycles got %0d exp %0d", busy, W); end
        n_vec++; if (result !== 8'h01 || result_hi !== 8'hFE) begin n_err++; $display("FAIL mul_product got %h%h exp fe01", result_hi, result); end
        n_vec++; if ({c_flag, dc_flag, z_flag} !== 3'b100) begin n_err++; $display("FAIL mul_flags got %b exp 100", {c_flag, dc_flag, z_flag}); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_ready_back got %b exp 1", in_ready); end
        @(negedge clk);
        idle8();
        n_vec++; if (out_valid !== 1'b1 || result !== 8'h5A || result_hi !== 8'h00) begin n_err++; $display("FAIL held_mov got ov=%b %h/%h exp 1 00/5a", out_valid, result_hi, result); end
        n_vec++; if ({c_flag, dc_flag, z_flag} !== 3'b010) begin n_err++; $display("FAIL held_mov_flags got %b exp 010", {c_flag, dc_flag, z_flag}); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL held_mov_strobe_end got %b exp 0", out_valid); end
        mc = 0; mdc = 1; mz = 0;
    endtask

    task automatic test_mul_reset();
        int seen;
        @(negedge clk);
        drive8(13, 'h37, 'h2B, 0, 3'b000);
        @(negedge clk);
        idle8();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_low got %b exp 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after got %b exp 1", in_ready); end
        n_vec++; if ({c_flag, dc_flag, z_flag} !== 3'b000 || result !== '0 || result_hi !== '0) begin n_err++; $display("FAIL rst_state got cdz=%b %h/%h exp 000 00/00", {c_flag, dc_flag, z_flag}, result_hi, result); end
        seen = 0;
        repeat (12) begin
            if (out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL rst_aborted_strobe got %0d strobes exp 0", seen); end
        drive8(1, 'h00, 'h00, 0, 3'b000);
        @(negedge clk);
        idle8();
        n_vec++; if (out_valid !== 1'b1 || {c_flag, dc_flag, z_flag} !== 3'b001) begin n_err++; $display("FAIL mov_zero got ov=%b cdz=%b exp 1/001", out_valid, {c_flag, dc_flag, z_flag}); end
        mc = 0; mdc = 0; mz = 1;
    endtask

    task automatic test_random_mul();
        longint a, b, er, eh;
        bit ec, edc, ez, bc, bdc, bz, fl;
        logic [2:0] fin;
        int lat;
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            if (i == 0) b = 0;
            fl = ($urandom_range(0, 1) == 1); fin = 3'($urandom_range(0, 7));
            {bc, bdc, bz} = fl ? fin : {mc, mdc, mz};
            ref_alu(W, 4, 13, a, b, mc, bc, bdc, bz, er, eh, ec, edc, ez);
            @(negedge clk);
            drive8(13, a, b, fl, fin);
            @(negedge clk);
            idle8();
            lat = 0;
            while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
            n_vec++; if (lat != W) begin n_err++; $display("FAIL rmul_latency[%0d] got %0d exp %0d", i, lat, W); end
            n_vec++; if ({result_hi, result} !== 16'(er + eh * 256)) begin n_err++; $display("FAIL rmul_product[%0d] %h*%h got %h%h exp %h", i, a, b, result_hi, result, 16'(er + eh * 256)); end
            n_vec++; if ({c_flag, dc_flag, z_flag} !== {ec, edc, ez}) begin n_err++; $display("FAIL rmul_flags[%0d] got %b exp %b", i, {c_flag, dc_flag, z_flag}, {ec, edc, ez}); end
            mc = ec; mdc = edc; mz = ez;
        end
    endtask

    task automatic test_back_to_back();
        longint a, b, er, eh;
        bit ec, edc, ez, bc, bdc, bz, fl;
        logic [2:0] fin, gf;
        logic [W-1:0] gr;
        int opc;
        for (int i = 0; i <= 60; i++) begin
            @(negedge clk);
            if (i > 0) begin
                gr = exp_q.pop_front(); gf = expf_q.pop_front();
                n_vec++; if (out_valid !== 1'b1 || result_hi !== '0) begin n_err++; $display("FAIL b2b_strobe[%0d] got ov=%b hi=%h exp 1/00", i, out_valid, result_hi); end
                n_vec++; if (result !== gr) begin n_err++; $display("FAIL b2b_result[%0d] got %h exp %h", i, result, gr); end
                n_vec++; if ({c_flag, dc_flag, z_flag} !== gf) begin n_err++; $display("FAIL b2b_flags[%0d] got %b exp %b", i, {c_flag, dc_flag, z_flag}, gf); end
            end
            if (i < 60) begin
                do opc = $urandom_range(0, 15); while (opc == 13);
                a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                fl = ($urandom_range(0, 3) == 0); fin = 3'($urandom_range(0, 7));
                {bc, bdc, bz} = fl ? fin : {mc, mdc, mz};
                ref_alu(W, 4, opc, a, b, mc, bc, bdc, bz, er, eh, ec, edc, ez);
                mc = ec; mdc = edc; mz = ez;
                exp_q.push_back(W'(er)); expf_q.push_back({ec, edc, ez});
                drive8(opc, a, b, fl, fin);
            end else begin
                idle8();
            end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_strobe_end got %b exp 0", out_valid); end
    endtask

    task automatic test_wide();
        vec_t tbl[$];
        int lat;
        tbl.push_back('{2,  'h12AB, 0,      0, 3'b000, 'hAB12, 0,      0, 0, 0});
        tbl.push_back('{9,  'h00FF, 'h0001, 0, 3'b000, 'h0100, 0,      0, 1, 0});
        tbl.push_back('{15, 'h1234, 0,      0, 3'b000, 'h1234, 0,      0, 1, 0});
        tbl.push_back('{13, 'hFFFF, 'hFFFF, 0, 3'b000, 'h0001, 'hFFFE, 1, 1, 0});
        tbl.push_back('{10, 'h0100, 'h0001, 0, 3'b000, 'h00FF, 0,      1, 0, 0});
        foreach (tbl[i]) begin
            @(negedge clk);
            w_in_valid = 1'b1; w_op = 4'(tbl[i].opc); w_op_a = WW'(tbl[i].a); w_op_b = WW'(tbl[i].b);
            w_flag_load = tbl[i].fl; w_flags_in = tbl[i].fin;
            @(negedge clk);
            w_in_valid = 1'b0; w_flag_load = 1'b0;
            lat = 0;
            while (w_out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
            n_vec++; if (lat != ((tbl[i].opc == 13) ? WW : 0)) begin n_err++; $display("FAIL wide_latency[%0d] got %0d", i, lat); end
            n_vec++; if (w_result !== WW'(tbl[i].er) || w_result_hi !== WW'(tbl[i].eh)) begin n_err++; $display("FAIL wide_result[%0d] got %h/%h exp %h/%h", i, w_result_hi, w_result, WW'(tbl[i].eh), WW'(tbl[i].er)); end
            n_vec++; if ({w_c_flag, w_dc_flag, w_z_flag} !== {tbl[i].ec, tbl[i].edc, tbl[i].ez}) begin n_err++; $display("FAIL wide_flags[%0d] got %b exp %b", i, {w_c_flag, w_dc_flag, w_z_flag}, {tbl[i].ec, tbl[i].edc, tbl[i].ez}); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_sub_pair();
        test_directed8();
        test_mul_hold();
        test_mul_reset();
        test_random_mul();
        test_back_to_back();
        test_wide();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
